// File: rtl/instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader
//
// Takes decoded RV32I instruction fields over a valid/ready handshake,
// assembles each bundle into its 32-bit instruction word and writes the words
// to consecutive instruction-memory addresses through an acknowledged write
// port. Used for boot-time program load and as a stimulus source.
//
// Optional feature macro: ENC_RANGE_CHECK_EN
//   defined   - immediates outside the legal range of their format are
//               consumed, not written, and flagged with err_code 11.
//   undefined - out-of-format immediate bits are silently truncated.
//
// Parameters
//   ADDR_W     word-address width of the memory port
//   DEPTH      memory capacity in words (<= 2**ADDR_W)
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             begin a new load session at word address 0
//   in_valid/in_ready field bundle handshake
//   in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, in_last
//                     decoded fields; in_last marks the final instruction
//   mem_we, mem_addr, mem_wdata, mem_ack
//                     write request, held stable until mem_ack
//   busy, done        in LOAD/WRITE, in DONE
//   err, err_code     sticky error and code of the first error
//                     (01 illegal opcode, 10 overflow, 11 immediate range)
//   word_count        words written this session
// ----------------------------------------------------------------------------
module instr_encoder_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_opcode,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   typedef enum logic [2:0] {
      FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
   } fmt_t;

   localparam logic [1:0] ERR_OPCODE   = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;
   localparam logic [1:0] ERR_RANGE    = 2'b11;

   // word_count value just before the write that fills the memory
   localparam logic [ADDR_W:0] FULL_BEFORE_ACK = (ADDR_W+1)'(DEPTH - 1);

   state_t            state, state_next;
   fmt_t              fmt;
   logic [31:0]       enc_word;
   logic              imm_ok;
   logic              last_q;
   logic              err_req;
   logic [1:0]        err_req_code;

   // ---------------------------------------------------------------- format
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      fmt = FMT_BAD;
      case (in_opcode)
         7'b0110011:                        fmt = FMT_R;
         7'b0010011:                        fmt = (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                                                  ? FMT_SH : FMT_I;
         7'b0000011, 7'b1100111:            fmt = FMT_I;
         7'b0100011:                        fmt = FMT_S;
         7'b1100011:                        fmt = FMT_B;
         7'b0110111, 7'b0010111:            fmt = FMT_U;
         7'b1101111:                        fmt = FMT_J;
         default:                           fmt = FMT_BAD;
      endcase
   end

   // -------------------------------------------------------------- encoder
   always_comb begin
      enc_word = '0;
      case (fmt)
         FMT_R:  enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_I:  enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         FMT_SH: enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
         FMT_S:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         FMT_B:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
         FMT_U:  enc_word = {in_imm[31:12], in_rd, in_opcode};
         FMT_J:  enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                             in_rd, in_opcode};
         default: enc_word = '0;
      endcase
   end

   // ---------------------------------------------------- immediate range
`ifdef ENC_RANGE_CHECK_EN
   // A value fits a signed field when all bits above it equal its sign bit.
   always_comb begin
      imm_ok = 1'b1;
      case (fmt)
         FMT_I, FMT_S: imm_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
         FMT_SH:       imm_ok = ~(|in_imm[31:5]);
         FMT_B:        imm_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
         FMT_J:        imm_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
         FMT_U:        imm_ok = ~(|in_imm[11:0]);
         default:      imm_ok = 1'b1;
      endcase
   end
`else
   assign imm_ok = 1'b1;
`endif

   // ------------------------------------------------------ next state/outputs
   always_comb begin
      state_next   = state;
      err_req      = 1'b0;
      err_req_code = 2'b00;
      in_ready     = (state == LOAD);
      mem_we       = (state == WRITE);
      busy         = (state == LOAD) || (state == WRITE);
      done         = (state == DONE);

      // start outranks in_valid and mem_ack in every state
      if (start) begin
         state_next = LOAD;
      end else begin
         case (state)
            LOAD: if (in_valid) begin
               if (fmt == FMT_BAD) begin
                  err_req      = 1'b1;
                  err_req_code = ERR_OPCODE;
               end else if (!imm_ok) begin
                  err_req      = 1'b1;
                  err_req_code = ERR_RANGE;
               end else begin
                  state_next = WRITE;
               end
            end
            WRITE: if (mem_ack) begin
               if (last_q) begin
                  state_next = DONE;
               end else if (word_count == FULL_BEFORE_ACK) begin
                  state_next   = DONE;
                  err_req      = 1'b1;
                  err_req_code = ERR_OVERFLOW;
               end else begin
                  state_next = LOAD;
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         last_q     <= 1'b0;
         word_count <= '0;
         err        <= 1'b0;
         err_code   <= 2'b00;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state <= state_next;
         if (start) begin
            mem_addr   <= '0;
            word_count <= '0;
            err        <= 1'b0;
            err_code   <= 2'b00;
         end else begin
            if (state == LOAD && state_next == WRITE) begin
               mem_wdata <= enc_word;
               last_q    <= in_last;
            end
            if (state == WRITE && mem_ack) begin
               mem_addr   <= mem_addr + 1'b1;
               word_count <= word_count + 1'b1;
            end
            if (err_req) begin
               err <= 1'b1;
               if (!err) err_code <= err_req_code;   // first error wins
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// Self-checking bench for instr_encoder_loader: directed cases for the
// documented encodings and corner cases, then randomized sessions checked
// against an arithmetic reference encoder and a simple session model.
// ----------------------------------------------------------------------------
module tb_instr_encoder_loader;

   localparam int ADDR_W = 3;
   localparam int DEPTH  = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [6:0]        in_opcode = '0;
   logic [2:0]        in_funct3 = '0;
   logic [6:0]        in_funct7 = '0;
   logic [4:0]        in_rd = '0;
   logic [4:0]        in_rs1 = '0;
   logic [4:0]        in_rs2 = '0;
   logic [31:0]       in_imm = '0;
   logic              in_last = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ack = 1'b0;
   logic              busy;
   logic              done;
   logic              err;
   logic [1:0]        err_code;
   logic [ADDR_W:0]   word_count;

   int checks = 0;
   int errors = 0;

   // session model
   int       exp_count;
   bit       exp_err;
   int       exp_code;
   bit       exp_done;

   instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_imm(in_imm), .in_last(in_last),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .busy(busy), .done(done),
      .err(err), .err_code(err_code), .word_count(word_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------ reference model
   // 0 = legal, 1 = illegal opcode, 3 = immediate out of range
   function automatic int ref_class(input logic [31:0] op, input logic [31:0] f3,
                                    input logic [31:0] imm);
      int s;
      s = int'(imm);
      case (op)
         32'h33: return 0;
         32'h13: begin
`ifdef ENC_RANGE_CHECK_EN
            if (f3 == 1 || f3 == 5) return (imm <= 31) ? 0 : 3;
            return (s >= -2048 && s <= 2047) ? 0 : 3;
`else
            return 0;
`endif
         end
`ifdef ENC_RANGE_CHECK_EN
         32'h03, 32'h67, 32'h23: return (s >= -2048 && s <= 2047) ? 0 : 3;
         32'h63: return (s >= -4096 && s <= 4094 && s % 2 == 0) ? 0 : 3;
         32'h37, 32'h17: return (imm % 4096 == 0) ? 0 : 3;
         32'h6F: return (s >= -1048576 && s <= 1048574 && s % 2 == 0) ? 0 : 3;
`else
         32'h03, 32'h67, 32'h23, 32'h63, 32'h37, 32'h17, 32'h6F: return 0;
`endif
         default: return 1;
      endcase
   endfunction

   function automatic logic [31:0] ref_encode(
      input logic [31:0] op, input logic [31:0] f3, input logic [31:0] f7,
      input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
      input logic [31:0] imm);
      logic [31:0] base;
      base = (rs1 << 15) | (f3 << 12) | op;
      case (op)
         32'h33: return (f7 << 25) | (rs2 << 20) | base | (rd << 7);
         32'h13: if (f3 == 1 || f3 == 5)
                    return (f7 << 25) | ((imm & 31) << 20) | base | (rd << 7);
                 else
                    return ((imm & 32'hFFF) << 20) | base | (rd << 7);
         32'h03, 32'h67: return ((imm & 32'hFFF) << 20) | base | (rd << 7);
         32'h23: return (((imm >> 5) & 127) << 25) | (rs2 << 20) | base | ((imm & 31) << 7);
         32'h63: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
                        | base | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7);
         32'h37, 32'h17: return (imm & 32'hFFFFF000) | (rd << 7) | op;
         32'h6F: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                        | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12)
                        | (rd << 7) | op;
         default: return 32'h0;
      endcase
   endfunction

   // ------------------------------------------------------------- drivers
   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_count = 0; exp_err = 0; exp_code = 0; exp_done = 0;
      check("start_busy", busy, 1);
      check("start_ready", in_ready, 1);
      check("start_count", word_count, 0);
      check("start_err", err, 0);
      check("start_code", err_code, 0);
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
      in_opcode = op; in_funct3 = f3; in_funct7 = f7;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
      in_valid = 1'b1;
   endtask

   // Offers one bundle (assumes the caller is at a negedge) and checks the
   // whole write transaction against the model; ack comes after 'delay' cycles.
   task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic last, input int delay);
      int cls;
      logic [31:0] w;
      int guard;
      cls = ref_class(32'(op), 32'(f3), imm);
      w   = ref_encode(32'(op), 32'(f3), 32'(f7), 32'(rd), 32'(rs1), 32'(rs2), imm);
      guard = 0;
      while (in_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (in_ready !== 1'b1) begin
         check("ready_timeout", in_ready, 1);
         return;
      end
      drive(op, f3, f7, rd, rs1, rs2, imm, last);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (cls != 0) begin
         if (!exp_err) begin exp_err = 1; exp_code = cls; end
         check("bad_no_write", mem_we, 0);
         check("bad_ready", in_ready, 1);
         check("bad_addr", mem_addr, 32'(exp_count % (1 << ADDR_W)));
         check("bad_err", err, exp_err);
         check("bad_code", err_code, exp_code);
         return;
      end
      check("we", mem_we, 1);
      check("ready_write", in_ready, 0);
      check("addr", mem_addr, 32'(exp_count % (1 << ADDR_W)));
      check("wdata", mem_wdata, w);
      for (int d = 0; d < delay; d++) begin
         @(negedge clk);
         check("hold_we", mem_we, 1);
         check("hold_ready", in_ready, 0);
         check("hold_addr", mem_addr, 32'(exp_count % (1 << ADDR_W)));
         check("hold_wdata", mem_wdata, w);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      exp_count++;
      if (last) begin
         exp_done = 1;
      end else if (exp_count == DEPTH) begin
         exp_done = 1;
         if (!exp_err) begin exp_err = 1; exp_code = 2; end
      end
      check("we_drop", mem_we, 0);
      check("count", word_count, exp_count);
      check("done", done, exp_done);
      check("ready_after", in_ready, !exp_done);
      check("err", err, exp_err);
      check("err_code", err_code, exp_code);
   endtask

   function automatic logic [31:0] rand_imm(input logic [6:0] op, input logic [2:0] f3);
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) return r;
      case (op)
         7'h13: return (f3 == 1 || f3 == 5) ? 32'($urandom_range(0, 31))
                                            : {{20{r[11]}}, r[11:0]};
         7'h03, 7'h67, 7'h23: return {{20{r[11]}}, r[11:0]};
         7'h63: return {{19{r[12]}}, r[12:1], 1'b0};
         7'h37, 7'h17: return {r[31:12], 12'h000};
         7'h6F: return {{11{r[20]}}, r[20:1], 1'b0};
         default: return r;
      endcase
   endfunction

   logic [6:0] legal_ops [9];

   initial begin
      legal_ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      check("rst_ready", in_ready, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_code", err_code, 0);
      check("rst_count", word_count, 0);

      // addi x1,x0,5 with ack in the same cycle as mem_we
      do_start();
      send(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 0);

      // add / sub, second is last
      do_start();
      send(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1);
      send(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 0);

      // beq, sw, jal
      do_start();
      send(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 0);
      send(7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 2);
      send(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 1);

      // mem_ack outside WRITE is ignored; stalled ack; illegal opcode
      do_start();
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("ack_in_load_count", word_count, 0);
      check("ack_in_load_addr", mem_addr, 0);
      check("ack_in_load_ready", in_ready, 1);
      send(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 3);
      send(7'h7F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 0);

      // start in WRITE with a simultaneous ack: start wins
      drive(7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check("mid_we", mem_we, 1);
      start = 1'b1;
      mem_ack = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mem_ack = 1'b0;
      check("abort_we", mem_we, 0);
      check("abort_count", word_count, 0);
      check("abort_addr", mem_addr, 0);
      check("abort_err", err, 0);
      check("abort_code", err_code, 0);
      check("abort_ready", in_ready, 1);
      exp_count = 0; exp_err = 0; exp_code = 0; exp_done = 0;

      // overflow: DEPTH writes without in_last
      do_start();
      for (int i = 0; i < DEPTH; i++)
         send(7'h13, 3'd0, 7'h00, 5'(i), 5'd0, 5'd0, 32'(i), 1'b0, i % 2);
      drive(7'h13, 3'd0, 7'h00, 5'd9, 5'd0, 5'd0, 32'd9, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_ready", in_ready, 0);
         check("full_we", mem_we, 0);
         check("full_count", word_count, DEPTH);
      end
      in_valid = 1'b0;

      // immediate 4096 on addi: range error or truncated write
      do_start();
      send(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1, 0);

      // randomized sessions
      for (int s = 0; s < 12; s++) begin
         int n;
         do_start();
         n = $urandom_range(1, DEPTH + 2);
         for (int i = 0; i < n && !exp_done; i++) begin
            logic [6:0] op;
            logic [2:0] f3;
            if ($urandom_range(0, 9) == 0) begin
               op = 7'($urandom);
               if (ref_class(32'(op), 32'd0, 32'd0) == 0) op = 7'h7F;
            end else begin
               op = legal_ops[$urandom_range(0, 8)];
            end
            f3 = 3'($urandom);
            send(op, f3, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 rand_imm(op, f3), (i == n - 1), $urandom_range(0, 3));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
